// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM fade sequencer and its prescaler.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic {IDLE, RAMP} fade_state_t;

  function automatic int clk_per_us(input int freq_hz);
    return freq_hz / 1000000;
  endfunction

endpackage

// File: rtl/pwm_us_tick.sv
// Free-running prescaler: tick_o pulses on the terminal count (C_DIV-1) while run_i is high.
// clear_i restarts the count at 0 and suppresses the tick for that cycle.
module pwm_us_tick #(
  parameter int C_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(C_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && !clear_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for an 8-bit PWM: accepts target/rate commands and ramps duty in 1-LSB steps.
// Optional continuous breathing between 0 and target when PWM_FADE_BREATHE_EN is defined.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int C_CLK_FREQ_HZ = 100000000,
  parameter int C_RATE_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DUTY_W-1:0]      cmd_target,
  input  logic [C_RATE_BITS-1:0] cmd_rate,
  input  logic                   cmd_enable,
`ifdef PWM_FADE_BREATHE_EN
  input  logic                   cmd_breathe,
`endif
  input  logic                   abort,
  output logic [DUTY_W-1:0]      duty_cycle,
  output logic                   duty_cycle_valid,
  output logic                   enable,
  output logic                   busy,
  output logic                   done
);

  localparam int CLK_PER_US = clk_per_us(C_CLK_FREQ_HZ);

  fade_state_t            state_q, state_d;
  logic [DUTY_W-1:0]      duty_q, duty_d;
  logic [DUTY_W-1:0]      target_q, target_d;
  logic [DUTY_W-1:0]      end_q, end_d;
  logic [C_RATE_BITS-1:0] rate_q, rate_d;
  logic [C_RATE_BITS-1:0] dwell_q, dwell_d;
  logic                   vld_q, vld_d;
  logic                   done_q, done_d;
  logic                   en_q, en_d;
  logic                   breathe_q, breathe_d;

  logic                   accept;
  logic                   us_tick;
  logic                   breathe_in;
  logic [DUTY_W-1:0]      step_duty;

`ifdef PWM_FADE_BREATHE_EN
  assign breathe_in = cmd_breathe;
`else
  assign breathe_in = 1'b0;
`endif

  assign cmd_ready        = (state_q == IDLE) && !reset;
  assign accept           = cmd_valid && cmd_ready;
  assign busy             = (state_q == RAMP);
  assign duty_cycle       = duty_q;
  assign duty_cycle_valid = vld_q;
  assign done             = done_q;
  assign enable           = en_q;

  // end_q is the current ramp endpoint and always differs from duty_q in RAMP,
  // so stepping toward it can never overshoot or wrap.
  assign step_duty = (end_q > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);

  pwm_us_tick #(
    .C_DIV (CLK_PER_US)
  ) u_us_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .run_i   (state_q == RAMP),
    .tick_o  (us_tick)
  );

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    end_d     = end_q;
    rate_d    = rate_q;
    dwell_d   = dwell_q;
    en_d      = en_q;
    breathe_d = breathe_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          en_d     = cmd_enable;
          target_d = cmd_target;
          end_d    = cmd_target;
          rate_d   = cmd_rate;
          dwell_d  = '0;
          // A zero target has no distinct turnaround point, so it fades once and stops.
          breathe_d = breathe_in && (cmd_target != '0);
          if (!cmd_enable) begin
            done_d = 1'b1;
          end else if ((cmd_rate == '0) || (cmd_target == duty_q)) begin
            duty_d = cmd_target;
            vld_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (us_tick) begin
          if (dwell_q == rate_q - C_RATE_BITS'(1)) begin
            dwell_d = '0;
            duty_d  = step_duty;
            vld_d   = 1'b1;
            if (step_duty == end_q) begin
              if (breathe_q) begin
                end_d = (end_q == '0) ? target_q : '0;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            dwell_d = dwell_q + C_RATE_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      end_q     <= '0;
      rate_q    <= '0;
      dwell_q   <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      breathe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      end_q     <= end_d;
      rate_q    <= rate_d;
      dwell_q   <= dwell_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      en_q      <= en_d;
      breathe_q <= breathe_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl at 4 clocks per microsecond.
`timescale 1ns/1ps
module tb_pwm_fade_ctrl;

  localparam int FREQ = 4000000;
  localparam int CPU  = 4;
  localparam int RB   = 16;

  typedef struct {
    logic       vld;
    logic       done;
    logic [7:0] duty;
    logic       en;
    int         cyc;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_target = '0;
  logic [RB-1:0] cmd_rate = '0;
  logic          cmd_enable = 1'b0;
  logic          cmd_breathe = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    duty_cycle;
  logic          duty_cycle_valid;
  logic          enable;
  logic          busy;
  logic          done;

  evt_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_evt = 0;
  logic [7:0] md = '0;

  pwm_fade_ctrl #(
    .C_CLK_FREQ_HZ (FREQ),
    .C_RATE_BITS   (RB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_target       (cmd_target),
    .cmd_rate         (cmd_rate),
    .cmd_enable       (cmd_enable),
`ifdef PWM_FADE_BREATHE_EN
    .cmd_breathe      (cmd_breathe),
`endif
    .abort            (abort),
    .duty_cycle       (duty_cycle),
    .duty_cycle_valid (duty_cycle_valid),
    .enable           (enable),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every strobe or done pulse must match the head of the queue.
  always @(negedge clk) begin
    evt_t e;
    if (!reset && (duty_cycle_valid || done)) begin
      n_evt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", {22'd0, enable, duty_cycle_valid, done, duty_cycle}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_duty", duty_cycle, e.duty);
        chk("evt_vld", duty_cycle_valid, e.vld);
        chk("evt_done", done, e.done);
        chk("evt_en", enable, e.en);
        chk("evt_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic v, input logic d, input logic [7:0] dy, input logic e, input int c);
    evt_t x;
    x.vld = v; x.done = d; x.duty = dy; x.en = e; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic send_cmd(input logic [7:0] tgt, input int rate, input logic en,
                          input logic brth, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_target  = tgt;
    cmd_rate    = RB'(rate);
    cmd_enable  = en;
    cmd_breathe = brth;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  // Expected events of a non-breathing command accepted at cycle acc.
  task automatic model_cmd(input logic [7:0] tgt, input int rate, input logic en, input int acc);
    int i;
    if (!en) begin
      push(1'b0, 1'b1, md, 1'b0, acc);
    end else if (rate == 0 || tgt == md) begin
      md = tgt;
      push(1'b1, 1'b1, md, 1'b1, acc);
    end else begin
      i = 0;
      while (md != tgt) begin
        i++;
        md = (tgt > md) ? md + 8'd1 : md - 8'd1;
        push(1'b1, md == tgt, md, 1'b1, acc + i * rate * CPU);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int ev0;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_duty", duty_cycle, 8'h00);
    chk("rst_vld", duty_cycle_valid, 1'b0);
    chk("rst_en", enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Immediate jump
    send_cmd(8'h80, 0, 1'b1, 1'b0, acc);
    model_cmd(8'h80, 0, 1'b1, acc);
    wait_drain(20);
    chk("jump_busy", busy, 1'b0);
    chk("jump_en", enable, 1'b1);

    // Ramp up, exactly three strobes
    ev0 = n_evt;
    send_cmd(8'h83, 2, 1'b1, 1'b0, acc);
    model_cmd(8'h83, 2, 1'b1, acc);
    chk("ramp_busy", busy, 1'b1);
    chk("ramp_ready", cmd_ready, 1'b0);
    wait_drain(100);
    repeat (20) @(negedge clk);
    chk("ramp_strobes", n_evt - ev0, 3);
    chk("ramp_idle", busy, 1'b0);

    // Ramp down, aborted after reaching 0x81
    send_cmd(8'h00, 1, 1'b1, 1'b0, acc);
    push(1'b1, 1'b0, 8'h82, 1'b1, acc + CPU);
    push(1'b1, 1'b0, 8'h81, 1'b1, acc + 2 * CPU);
    wait_drain(100);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    md = 8'h81;
    chk("abort_busy", busy, 1'b0);
    chk("abort_duty", duty_cycle, 8'h81);
    chk("abort_ready", cmd_ready, 1'b1);
    repeat (16) @(negedge clk);

    // Command held during a ramp waits for IDLE, then disables
    send_cmd(8'h85, 1, 1'b1, 1'b0, acc);
    model_cmd(8'h85, 1, 1'b1, acc);
    cmd_target = 8'hFF;
    cmd_rate   = RB'(3);
    cmd_enable = 1'b0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    chk("held_ready", cmd_ready, 1'b0);
    model_cmd(8'hFF, 3, 1'b0, acc + 4 * CPU + 1);
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_drain(50);
    chk("dis_en", enable, 1'b0);
    chk("dis_duty", duty_cycle, 8'h85);

    // Target equal to current duty: strobe and done with no ramp
    send_cmd(8'h85, 5, 1'b1, 1'b0, acc);
    model_cmd(8'h85, 5, 1'b1, acc);
    wait_drain(20);

    // Upper and lower boundaries
    send_cmd(8'hFD, 0, 1'b1, 1'b0, acc);
    model_cmd(8'hFD, 0, 1'b1, acc);
    wait_drain(20);
    send_cmd(8'hFF, 1, 1'b1, 1'b0, acc);
    model_cmd(8'hFF, 1, 1'b1, acc);
    wait_drain(50);
    send_cmd(8'h02, 0, 1'b1, 1'b0, acc);
    model_cmd(8'h02, 0, 1'b1, acc);
    wait_drain(20);
    send_cmd(8'h00, 1, 1'b1, 1'b0, acc);
    model_cmd(8'h00, 1, 1'b1, acc);
    wait_drain(50);
    repeat (12) @(negedge clk);
    chk("floor_duty", duty_cycle, 8'h00);

`ifdef PWM_FADE_BREATHE_EN
    begin
      logic [7:0] seq [6];
      seq = '{8'h01, 8'h02, 8'h01, 8'h00, 8'h01, 8'h02};
      send_cmd(8'h02, 1, 1'b1, 1'b1, acc);
      for (int i = 0; i < 6; i++) push(1'b1, 1'b0, seq[i], 1'b1, acc + (i + 1) * CPU);
      wait_drain(100);
      chk("breathe_busy", busy, 1'b1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("breathe_abort_busy", busy, 1'b0);
      chk("breathe_abort_duty", duty_cycle, 8'h02);
      md = 8'h02;
      repeat (12) @(negedge clk);
    end
`endif

    // Reset in the middle of a ramp discards it
    send_cmd(8'h10, 3, 1'b1, 1'b0, acc);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_duty", duty_cycle, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_en", enable, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
